timer_mmio: RTL and testbench
=============================

# timer_mmio

Memory-mapped interval timer that answers the timer window of the data-side address decoder. The decoder forwards CPU stores at 0x2018 as a one-cycle write strobe plus data, and returns this block's status word for CPU loads at 0x201C. The block counts programmable intervals in prescaled ticks and reports a sticky done flag that software polls and clears.

## Interface
- `Simulacion`, default 0: when 1, the prescaler divides by 4 so simulations stay short.
- `CLK_HZ`, default 100_000_000: frequency of `clk` in Hz.
- `TICK_HZ`, default 1000: tick rate when `Simulacion`=0. `DIV` = `CLK_HZ`/`TICK_HZ` must be ≥ 2.
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `ctrl_we`  in  1  one-cycle write strobe for the control register at 0x2018.
- `ctrl_wdata`  in  32  control word, sampled on the rising edge of `clk` while `ctrl_we`=1.
- `done_rdata`  out  32  status word read at 0x201C: {`remaining`[15:0], 14'b0, `busy`, `done`}.
- `done_pulse`  out  1  one-cycle pulse on the edge where the timer enters DONE.

## Operation
- Control word fields:
  - bit0 START.
  - bit1 STOP.
  - bit2 CLR_DONE.
  - bits[31:16] N, the interval length in ticks.
  - bits[15:3] reserved, ignored.
- Internal registers:
  - `state` ∈ {IDLE, RUN, DONE}.
  - `remaining` (16 bits).
  - `pre_cnt`, wide enough to hold `DIV`-1.
- Command priority when `ctrl_we`=1: STOP > START > CLR_DONE. A write with none of the three bits set has no effect.
- STOP, from any state: go to IDLE, `remaining`←0, `pre_cnt`←0.
- START with N≠0, from any state (restarts a running interval): go to RUN, `remaining`←N, `pre_cnt`←0.
- START with N=0: go directly to DONE, `remaining`←0, `done_pulse`=1 for that cycle.
- CLR_DONE:
  - In DONE: go to IDLE.
  - In IDLE or RUN: ignored.
- RUN behaviour, each edge with no command:
  - If `pre_cnt` = `DIV`-1: a tick occurs, `pre_cnt`←0, `remaining`←`remaining`-1.
  - Otherwise: `pre_cnt`←`pre_cnt`+1.
  - A tick that takes `remaining` from 1 to 0 moves the state to DONE and raises `done_pulse` for one cycle.
- In IDLE and DONE, `pre_cnt` and `remaining` hold their values. The decrement never wraps below 0.
- Status decoding: `busy` = (state==RUN); `done` = (state==DONE). `done_rdata` is derived combinationally from registered state only; no combinational path from `ctrl_*` to outputs.

## Timing
- Reset values: `state`=IDLE, `remaining`=0, `pre_cnt`=0, `done_rdata`=32'h0, `done_pulse`=0. Reset is asynchronous, so outputs clear without a clock edge.
- Reset asserted in the middle of an interval aborts it with no `done_pulse`.
- Write latency: the effect of a write sampled at edge E0 is visible in `done_rdata` after E0, i.e. one cycle.
- START with N≠0 at edge E0:
  - The tick decrements occur at edges E0+k·`DIV`, k=1..N.
  - `done` rises after edge E0+N·`DIV`.
  - `done_pulse` is high in the cycle following that edge.
- START with N=0 at E0: `done` and `done_pulse` after E0.
- `done_pulse` width is exactly 1 cycle per entry into DONE. It is also 1 cycle on a restart from DONE with N=0.
- `done` remains set until CLR_DONE, STOP, START, or reset.
- A read at 0x201C returns the value after the last completed edge.

## Test plan
- Basic interval (`Simulacion`=1, so `DIV`=4): after reset, write 0x0003_0001 at E0.
  - `done_rdata`=0x0003_0002 after E0 and 0x0002_0002 after E0+4.
  - `done_rdata`=0x0000_0001 after E0+12, with `done_pulse` high for 1 cycle.
- Zero length: write 0x0000_0001 → `done_rdata`=0x0000_0001 and `done_pulse`=1 after one edge; no RUN cycle is ever observed.
- Stop and priority:
  - Start N=5, then 6 cycles later write 0x0000_0002 → `done_rdata`=0 next cycle, and no pulse for 30 cycles.
  - Write 0x0005_0003 (START+STOP) → stays IDLE.
- Restart in RUN: start N=5; at E0+7 write 0x0002_0001 → `done` rises exactly 8 cycles after the second write, not before; exactly one `done_pulse`.
- Clear done:
  - In DONE, write 0x0000_0004 → `done_rdata`=0.
  - In RUN, write 0x0000_0004 → no change to `remaining`, `busy`, or timing.
  - Reserved-only write 0x0000_FFF8 → no effect.
- Asynchronous reset: assert `reset` mid-RUN between clock edges → `done_rdata`=0 immediately, no `done_pulse` after release, and a subsequent START works normally.

Source files
------------

// File: rtl/timer_mmio.sv
// Memory-mapped interval timer: counts N prescaled ticks after START and raises a
// sticky done flag (with a one-cycle pulse) that software polls and clears.
module timer_mmio #(
    parameter bit          Simulacion = 1'b0,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TICK_HZ    = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_we,
    input  logic [31:0] ctrl_wdata,
    output logic [31:0] done_rdata,
    output logic        done_pulse
);

    localparam int unsigned DIV = Simulacion ? 4 : CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PreMax = PW'(DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [15:0]   remaining_q, remaining_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic          pulse_q, pulse_d;

    logic        cmd_start, cmd_stop, cmd_clr;
    logic [15:0] n_val;
    logic        unused_rsvd;

    assign cmd_start   = ctrl_we & ctrl_wdata[0];
    assign cmd_stop    = ctrl_we & ctrl_wdata[1];
    assign cmd_clr     = ctrl_we & ctrl_wdata[2];
    assign n_val       = ctrl_wdata[31:16];
    assign unused_rsvd = ^ctrl_wdata[15:3];

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pre_cnt_d   = pre_cnt_q;
        pulse_d     = 1'b0;
        if (cmd_stop) begin
            state_d     = StIdle;
            remaining_d = '0;
            pre_cnt_d   = '0;
        end else if (cmd_start) begin
            pre_cnt_d = '0;
            if (n_val != 16'd0) begin
                state_d     = StRun;
                remaining_d = n_val;
            end else begin
                state_d     = StDone;
                remaining_d = '0;
                pulse_d     = 1'b1;
            end
        end else if (cmd_clr && state_q == StDone) begin
            state_d = StIdle;
        end else if (state_q == StRun) begin
            if (pre_cnt_q == PreMax) begin
                pre_cnt_d = '0;
                // Saturating decrement; reaching zero ends the interval.
                if (remaining_q != 16'd0) begin
                    remaining_d = remaining_q - 16'd1;
                end
                if (remaining_q <= 16'd1) begin
                    state_d = StDone;
                    pulse_d = 1'b1;
                end
            end else begin
                pre_cnt_d = pre_cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            pre_cnt_q   <= '0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pre_cnt_q   <= pre_cnt_d;
            pulse_q     <= pulse_d;
        end
    end

    assign done_rdata = {remaining_q, 14'b0, state_q == StRun, state_q == StDone};
    assign done_pulse = pulse_q;

endmodule

// File: tb/tb_timer_mmio.sv
// Directed bench for timer_mmio with the short prescaler (DIV = 4).
module tb_timer_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_we;
    logic [31:0] ctrl_wdata;
    logic [31:0] done_rdata;
    logic        done_pulse;

    int passed = 0;
    int total  = 0;

    timer_mmio #(.Simulacion(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl_we    (ctrl_we),
        .ctrl_wdata (ctrl_wdata),
        .done_rdata (done_rdata),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    // Write is sampled on the next rising edge; returns 1 time unit after it.
    task automatic do_write(input logic [31:0] data);
        @(negedge clk);
        ctrl_we    = 1'b1;
        ctrl_wdata = data;
        @(posedge clk);
        #1;
        ctrl_we    = 1'b0;
        ctrl_wdata = 32'h0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        ctrl_we    = 1'b0;
        ctrl_wdata = 32'h0;
        #1;
        total++;
        if (done_rdata !== 32'h0) $display("FAIL reset_rdata got %h want %h", done_rdata, 32'h0);
        else passed++;
        total++;
        if (done_pulse !== 1'b0) $display("FAIL reset_pulse got %b want 0", done_pulse);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        do_write(32'h0003_0001);
        total++;
        if (done_rdata !== 32'h0003_0002) $display("FAIL basic_e0 got %h want %h", done_rdata, 32'h0003_0002);
        else passed++;
        step(3);
        total++;
        if (done_rdata !== 32'h0003_0002) $display("FAIL basic_e3 got %h want %h", done_rdata, 32'h0003_0002);
        else passed++;
        step(1);
        total++;
        if (done_rdata !== 32'h0002_0002) $display("FAIL basic_e4 got %h want %h", done_rdata, 32'h0002_0002);
        else passed++;
        step(7);
        total++;
        if (done_rdata !== 32'h0001_0002 || done_pulse !== 1'b0)
            $display("FAIL basic_e11 got %h/%b want %h/0", done_rdata, done_pulse, 32'h0001_0002);
        else passed++;
        step(1);
        total++;
        if (done_rdata !== 32'h0000_0001 || done_pulse !== 1'b1)
            $display("FAIL basic_e12 got %h/%b want %h/1", done_rdata, done_pulse, 32'h0000_0001);
        else passed++;
        step(1);
        total++;
        if (done_rdata !== 32'h0000_0001 || done_pulse !== 1'b0)
            $display("FAIL basic_e13 got %h/%b want %h/0", done_rdata, done_pulse, 32'h0000_0001);
        else passed++;
    endtask

    task automatic test_zero_length;
        do_write(32'h0000_0004);
        total++;
        if (done_rdata !== 32'h0) $display("FAIL zero_clr got %h want %h", done_rdata, 32'h0);
        else passed++;
        do_write(32'h0000_0001);
        total++;
        if (done_rdata !== 32'h0000_0001 || done_pulse !== 1'b1)
            $display("FAIL zero_start got %h/%b want %h/1", done_rdata, done_pulse, 32'h0000_0001);
        else passed++;
        step(1);
        total++;
        if (done_pulse !== 1'b0) $display("FAIL zero_pulse_width got %b want 0", done_pulse);
        else passed++;
        // Restart from DONE with N=0 must pulse again.
        do_write(32'h0000_0001);
        total++;
        if (done_rdata !== 32'h0000_0001 || done_pulse !== 1'b1)
            $display("FAIL zero_restart got %h/%b want %h/1", done_rdata, done_pulse, 32'h0000_0001);
        else passed++;
    endtask

    task automatic test_stop_priority;
        int pulses = 0;
        int busy_seen = 0;
        do_write(32'h0005_0001);
        step(5);
        do_write(32'h0000_0002);
        total++;
        if (done_rdata !== 32'h0) $display("FAIL stop_rdata got %h want %h", done_rdata, 32'h0);
        else passed++;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (done_pulse === 1'b1) pulses++;
            if (done_rdata !== 32'h0) busy_seen++;
        end
        total++;
        if (pulses != 0 || busy_seen != 0)
            $display("FAIL stop_quiet got pulses=%0d nonzero=%0d want 0/0", pulses, busy_seen);
        else passed++;
        do_write(32'h0005_0003);
        total++;
        if (done_rdata !== 32'h0 || done_pulse !== 1'b0)
            $display("FAIL stop_over_start got %h/%b want %h/0", done_rdata, done_pulse, 32'h0);
        else passed++;
    endtask

    task automatic test_restart;
        int pulses = 0;
        do_write(32'h0005_0001);
        step(6);
        total++;
        if (done_rdata !== 32'h0004_0002) $display("FAIL restart_pre got %h want %h", done_rdata, 32'h0004_0002);
        else passed++;
        do_write(32'h0002_0001);
        total++;
        if (done_rdata !== 32'h0002_0002) $display("FAIL restart_load got %h want %h", done_rdata, 32'h0002_0002);
        else passed++;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (done_pulse === 1'b1) pulses++;
            if (i < 8 && done_rdata[0] !== 1'b0) begin
                total++;
                $display("FAIL restart_early got done=1 at cycle %0d want 0", i);
            end
        end
        total++;
        if (done_rdata !== 32'h0000_0001 || done_pulse !== 1'b1)
            $display("FAIL restart_done got %h/%b want %h/1", done_rdata, done_pulse, 32'h0000_0001);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (done_pulse === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1) $display("FAIL restart_pulses got %0d want 1", pulses);
        else passed++;
    endtask

    task automatic test_clear_done;
        do_write(32'h0000_0004);
        total++;
        if (done_rdata !== 32'h0) $display("FAIL clr_done got %h want %h", done_rdata, 32'h0);
        else passed++;
        do_write(32'h0003_0001);
        step(1);
        do_write(32'h0000_0004);
        total++;
        if (done_rdata !== 32'h0003_0002) $display("FAIL clr_in_run got %h want %h", done_rdata, 32'h0003_0002);
        else passed++;
        step(2);
        total++;
        if (done_rdata !== 32'h0002_0002) $display("FAIL clr_run_tick got %h want %h", done_rdata, 32'h0002_0002);
        else passed++;
        do_write(32'h0000_FFF8);
        total++;
        if (done_rdata !== 32'h0002_0002) $display("FAIL rsvd_in_run got %h want %h", done_rdata, 32'h0002_0002);
        else passed++;
        step(6);
        total++;
        if (done_rdata !== 32'h0001_0002) $display("FAIL clr_run_e11 got %h want %h", done_rdata, 32'h0001_0002);
        else passed++;
        step(1);
        total++;
        if (done_rdata !== 32'h0000_0001 || done_pulse !== 1'b1)
            $display("FAIL clr_run_e12 got %h/%b want %h/1", done_rdata, done_pulse, 32'h0000_0001);
        else passed++;
        do_write(32'h0000_FFF8);
        total++;
        if (done_rdata !== 32'h0000_0001 || done_pulse !== 1'b0)
            $display("FAIL rsvd_in_done got %h/%b want %h/0", done_rdata, done_pulse, 32'h0000_0001);
        else passed++;
    endtask

    task automatic test_async_reset;
        int pulses = 0;
        int nonzero = 0;
        do_write(32'h0004_0001);
        step(5);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (done_rdata !== 32'h0 || done_pulse !== 1'b0)
            $display("FAIL areset_now got %h/%b want %h/0", done_rdata, done_pulse, 32'h0);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (done_pulse === 1'b1) pulses++;
            if (done_rdata !== 32'h0) nonzero++;
        end
        total++;
        if (pulses != 0 || nonzero != 0)
            $display("FAIL areset_quiet got pulses=%0d nonzero=%0d want 0/0", pulses, nonzero);
        else passed++;
        do_write(32'h0001_0001);
        total++;
        if (done_rdata !== 32'h0001_0002) $display("FAIL areset_start got %h want %h", done_rdata, 32'h0001_0002);
        else passed++;
        step(4);
        total++;
        if (done_rdata !== 32'h0000_0001 || done_pulse !== 1'b1)
            $display("FAIL areset_done got %h/%b want %h/1", done_rdata, done_pulse, 32'h0000_0001);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_length();
        test_stop_priority();
        test_restart();
        test_clear_done();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
